// File: rtl/bin2bcd_trio_trigger_gen_pkg.sv
// bin2bcd_trio_trigger_gen_pkg: shared FSM encoding, BCD digit type and timing defaults
package bin2bcd_trio_trigger_gen_pkg;
    typedef enum logic [2:0] {IDLE, CONV, UPDATE, HOLD, GAP} state_e;
    typedef logic [3:0] bcd_t;
    localparam int BIN_W              = 10;
    localparam int BCD_DIGITS         = 3;
    localparam int WORK_W             = BIN_W + 4 * BCD_DIGITS;
    localparam int BCD_MAX            = 999;
    localparam int STEP_LENGTH        = 250;
    localparam int FRAME_STEPS        = 48;
    localparam int DEF_TRIG_HOLD      = 4;
    localparam int DEF_MIN_GAP        = STEP_LENGTH * FRAME_STEPS;
    localparam int DEF_REFRESH_CYCLES = 5_000_000;
    function automatic bcd_t add3(bcd_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/bin2bcd_trio_trigger_gen_if.sv
// bin2bcd_trio_trigger_gen_if: request/digit/trigger bundle between feeder and its user
interface bin2bcd_trio_trigger_gen_if;
    import bin2bcd_trio_trigger_gen_pkg::*;
    logic             start;
    logic [BIN_W-1:0] bin;
    bcd_t             num0;
    bcd_t             num1;
    bcd_t             num2;
    logic             trigger;
    logic             busy;
    logic             ovf;
    modport master (output start, bin, input num0, num1, num2, trigger, busy, ovf);
    modport slave  (input start, bin, output num0, num1, num2, trigger, busy, ovf);
endinterface

// File: rtl/bin2bcd_trio_trigger_gen_bcd_double_dabble_seq.sv
// bin2bcd_trio_trigger_gen_bcd_double_dabble_seq: one shift-add-3 iteration per step, 10 steps per value
module bin2bcd_trio_trigger_gen_bcd_double_dabble_seq
    import bin2bcd_trio_trigger_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [BIN_W-1:0] bin_i,
    output bcd_t             hund_o,
    output bcd_t             tens_o,
    output bcd_t             units_o,
    output logic             done_o
);
    logic [WORK_W-1:0] work_q, work_d, adj;
    logic [3:0]        cnt_q, cnt_d;
    always_comb begin
        adj    = {add3(work_q[WORK_W-1 -: 4]), add3(work_q[WORK_W-5 -: 4]),
                  add3(work_q[WORK_W-9 -: 4]), work_q[BIN_W-1:0]};
        work_d = load_i ? WORK_W'(bin_i) : step_i ? adj << 1 : work_q;
        cnt_d  = load_i ? '0 : step_i ? cnt_q + 1'b1 : cnt_q;
    end
    // high during the final step so the caller can leave CONV on that same edge
    assign done_o = step_i && cnt_q == 4'(BIN_W - 1);
    assign {hund_o, tens_o, units_o} = work_q[WORK_W-1:BIN_W];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/bin2bcd_trio_trigger_gen.sv
// bin2bcd_trio_trigger_gen: binary->3-digit BCD feeder with rate-limited held trigger for a 595 driver.
// Optional periodic re-trigger of the current digits with `define AUTO_REFRESH_EN.
module bin2bcd_trio_trigger_gen
    import bin2bcd_trio_trigger_gen_pkg::*;
#(
    parameter int TRIG_HOLD      = DEF_TRIG_HOLD,
    parameter int MIN_GAP        = DEF_MIN_GAP
`ifdef AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst_n,
    bin2bcd_trio_trigger_gen_if.slave bus
);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] HOLD_LAST = GAP_W'(TRIG_HOLD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(MIN_GAP - 1);
    state_e                   state_q, state_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [BIN_W-1:0]         cur_q, cur_d, pend_bin_q, pend_bin_d;
    logic                     pend_q, pend_d;
    logic [4*BCD_DIGITS-1:0]  num_q, num_d;
    logic                     ovf_q, ovf_d, trig_q;
    logic                     go, dd_load, dd_done, ref_fire;
    bcd_t                     dd_hund, dd_tens, dd_units;
    bin2bcd_trio_trigger_gen_bcd_double_dabble_seq u_dd (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (dd_load),
        .step_i  (state_q == CONV),
        .bin_i   (cur_d),
        .hund_o  (dd_hund),
        .tens_o  (dd_tens),
        .units_o (dd_units),
        .done_o  (dd_done)
    );
`ifdef AUTO_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    logic [REF_W-1:0] ref_q, ref_d;
    // counts only while truly idle; any trigger rise (HOLD with trigger still low) restarts the period
    assign ref_d    = (state_q == IDLE && !pend_q) ? ref_q + 1'b1 : (state_q == HOLD && !trig_q) ? '0 : ref_q;
    assign ref_fire = ref_q == REF_LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_q <= '0;
        else        ref_q <= ref_d;
    end
`else
    assign ref_fire = 1'b0;
`endif
    always_comb begin
        state_d    = state_q;
        gap_d      = (state_q == HOLD || state_q == GAP) ? gap_q + 1'b1 : gap_q;
        cur_d      = cur_q;
        pend_bin_d = (bus.start && state_q != IDLE) ? bus.bin : pend_bin_q;
        pend_d     = (bus.start && state_q != IDLE) || pend_q;
        num_d      = num_q;
        ovf_d      = ovf_q;
        go         = 1'b0;
        dd_load    = 1'b0;
        case (state_q)
            IDLE: begin
                go = bus.start || pend_q;
                if (!go && ref_fire) begin
                    state_d = HOLD;
                    gap_d   = '0;
                end
            end
            CONV:   state_d = dd_done ? UPDATE : CONV;
            UPDATE: begin
                ovf_d   = cur_q > BIN_W'(BCD_MAX);
                num_d   = ovf_d ? {4'd9, 4'd9, 4'd9} : {dd_hund, dd_tens, dd_units};
                state_d = HOLD;
                gap_d   = '0;
            end
            HOLD:   state_d = (gap_q == HOLD_LAST) ? GAP : HOLD;
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    go      = bus.start || pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // a fresh start beats a queued request; either one skips the idle cycle
        if (go) begin
            state_d = CONV;
            dd_load = 1'b1;
            cur_d   = bus.start ? bus.bin : pend_bin_q;
            pend_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            cur_q      <= '0;
            pend_q     <= 1'b0;
            pend_bin_q <= '0;
            num_q      <= '0;
            ovf_q      <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_bin_q <= pend_bin_d;
            num_q      <= num_d;
            ovf_q      <= ovf_d;
            trig_q     <= state_q == HOLD;
        end
    end
    assign bus.num0    = num_q[11:8];
    assign bus.num1    = num_q[7:4];
    assign bus.num2    = num_q[3:0];
    assign bus.ovf     = ovf_q;
    assign bus.trigger = trig_q;
    assign bus.busy    = state_q != IDLE || pend_q;
endmodule

// File: tb/tb_bin2bcd_trio_trigger_gen.sv
// tb_bin2bcd_trio_trigger_gen: randomized self-checking bench with a decimal-arithmetic reference model
module tb_bin2bcd_trio_trigger_gen;
    import bin2bcd_trio_trigger_gen_pkg::*;
    localparam int TH = 4;
    localparam int MG = 12000;
`ifdef AUTO_REFRESH_EN
    localparam int RC = 1000;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trig_prev = 1'b0;
    int tot = 0, bad = 0, cyc = 0, rise_cnt = 0;
    int rise_t[$];
    bin2bcd_trio_trigger_gen_if bus();
`ifdef AUTO_REFRESH_EN
    bin2bcd_trio_trigger_gen #(.TRIG_HOLD(TH), .MIN_GAP(MG), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    bin2bcd_trio_trigger_gen #(.TRIG_HOLD(TH), .MIN_GAP(MG)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.trigger && !trig_prev) begin
            rise_cnt++;
            rise_t.push_back(cyc);
        end
        trig_prev = bus.trigger;
    end
    function automatic logic [12:0] model(int b);
        return b > 999 ? {1'b1, 4'd9, 4'd9, 4'd9} : {1'b0, 4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
    endfunction
    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    task automatic pulse_start(input int b, input int n);
        bus.bin   = 10'(b);
        bus.start = 1'b1;
        repeat (n) @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_rise(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = rise_cnt >= n;
        end
    endtask
    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = bus.busy == 1'b0;
        end
    endtask
    task automatic test_reset;
        @(negedge clk);
        tot++; if ({bus.num0, bus.num1, bus.num2} !== 12'd0) begin bad++; $display("FAIL reset_digits got=%h want=000", {bus.num0, bus.num1, bus.num2}); end
        tot++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        tot++; if (bus.trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b want=0", bus.trigger); end
        tot++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tot++; if ({bus.trigger, bus.busy} !== 2'b00) begin bad++; $display("FAIL idle_quiet got=%b want=00", {bus.trigger, bus.busy}); end
    endtask
    task automatic test_conv(input int b);
        logic [12:0] exp;
        int w;
        exp = model(b);
        do_reset();
        pulse_start(b, 1);
        tot++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL conv_busy bin=%0d got=%b want=1", b, bus.busy); end
        repeat (10) @(negedge clk);
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== 13'd0) begin bad++; $display("FAIL conv_early bin=%0d got=%h want=0", b, {bus.ovf, bus.num0, bus.num1, bus.num2}); end
        @(negedge clk);
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== exp) begin bad++; $display("FAIL conv_digits bin=%0d got=%h want=%h", b, {bus.ovf, bus.num0, bus.num1, bus.num2}, exp); end
        tot++; if (bus.trigger !== 1'b0) begin bad++; $display("FAIL conv_setup bin=%0d got=%b want=0", b, bus.trigger); end
        @(negedge clk);
        tot++; if (bus.trigger !== 1'b1) begin bad++; $display("FAIL conv_rise bin=%0d got=%b want=1", b, bus.trigger); end
        w = 1;
        for (int i = 0; i < TH + 3; i++) begin
            @(negedge clk);
            if (bus.trigger) w++;
        end
        tot++; if (w !== TH) begin bad++; $display("FAIL conv_width bin=%0d got=%0d want=%0d", b, w, TH); end
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== exp) begin bad++; $display("FAIL conv_stable bin=%0d got=%h want=%h", b, {bus.ovf, bus.num0, bus.num1, bus.num2}, exp); end
    endtask
    task automatic test_fixed;
        test_conv(123);
        test_conv(0);
        test_conv(999);
        test_conv(1000);
        test_conv(1023);
    endtask
    task automatic test_random;
        for (int i = 0; i < 8; i++) test_conv(int'($urandom_range(0, 1023)));
    endtask
    task automatic test_back_to_back;
        bit ok;
        int iv;
        do_reset();
        rise_cnt = 0;
        rise_t.delete();
        pulse_start(456, 1);
        wait_rise(1, 50, ok);
        tot++; if (!ok) begin bad++; $display("FAIL b2b_first timeout got=%0d want=1", rise_cnt); end
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== model(456)) begin bad++; $display("FAIL b2b_first_digits got=%h want=%h", {bus.ovf, bus.num0, bus.num1, bus.num2}, model(456)); end
        repeat (100) @(negedge clk);
        pulse_start(789, 1);
        tot++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", bus.busy); end
        tot++; if ({bus.num0, bus.num1, bus.num2} !== 12'h456) begin bad++; $display("FAIL b2b_no_abort got=%h want=456", {bus.num0, bus.num1, bus.num2}); end
        wait_rise(2, MG + 100, ok);
        tot++; if (!ok) begin bad++; $display("FAIL b2b_second timeout got=%0d want=2", rise_cnt); end
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== model(789)) begin bad++; $display("FAIL b2b_second_digits got=%h want=%h", {bus.ovf, bus.num0, bus.num1, bus.num2}, model(789)); end
        iv = (rise_t.size() >= 2) ? rise_t[1] - rise_t[0] : 0;
        tot++; if (iv < MG || iv > MG + 40) begin bad++; $display("FAIL b2b_interval got=%0d want=%0d..%0d", iv, MG, MG + 40); end
        wait_idle(MG + 100, ok);
        repeat (50) @(negedge clk);
        tot++; if (!ok || rise_cnt != 2) begin bad++; $display("FAIL b2b_count idle=%b got=%0d want=2", ok, rise_cnt); end
    endtask
    task automatic test_reset_mid;
        rise_cnt = 0;
        pulse_start(321, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot++; if ({bus.ovf, bus.num0, bus.num1, bus.num2} !== 13'd0) begin bad++; $display("FAIL mid_reset_digits got=%h want=0", {bus.ovf, bus.num0, bus.num1, bus.num2}); end
        tot++; if ({bus.trigger, bus.busy} !== 2'b00) begin bad++; $display("FAIL mid_reset_ctrl got=%b want=00", {bus.trigger, bus.busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20000) @(negedge clk);
        tot++; if (rise_cnt != 0) begin bad++; $display("FAIL mid_reset_no_trigger got=%0d want=0", rise_cnt); end
    endtask
    task automatic test_held_start;
        bit ok;
        do_reset();
        rise_cnt = 0;
        rise_t.delete();
        pulse_start(42, 3);
        wait_rise(1, 50, ok);
        tot++; if (!ok || {bus.ovf, bus.num0, bus.num1, bus.num2} !== model(42)) begin bad++; $display("FAIL held_first ok=%b got=%h want=%h", ok, {bus.ovf, bus.num0, bus.num1, bus.num2}, model(42)); end
        wait_rise(2, MG + 100, ok);
        tot++; if (!ok || {bus.ovf, bus.num0, bus.num1, bus.num2} !== model(42)) begin bad++; $display("FAIL held_rerun ok=%b got=%h want=%h", ok, {bus.ovf, bus.num0, bus.num1, bus.num2}, model(42)); end
        wait_idle(MG + 100, ok);
        repeat (50) @(negedge clk);
        tot++; if (!ok || rise_cnt != 2) begin bad++; $display("FAIL held_count idle=%b got=%0d want=2", ok, rise_cnt); end
    endtask
`ifdef AUTO_REFRESH_EN
    task automatic test_refresh;
        bit ok;
        int b, iv;
        b = int'($urandom_range(0, 999));
        do_reset();
        rise_cnt = 0;
        rise_t.delete();
        pulse_start(b, 1);
        wait_rise(1, 50, ok);
        tot++; if (!ok) begin bad++; $display("FAIL refresh_first timeout got=%0d want=1", rise_cnt); end
        wait_rise(2, MG + RC + 200, ok);
        tot++; if (!ok || {bus.ovf, bus.num0, bus.num1, bus.num2} !== model(b)) begin bad++; $display("FAIL refresh_digits ok=%b got=%h want=%h", ok, {bus.ovf, bus.num0, bus.num1, bus.num2}, model(b)); end
        iv = (rise_t.size() >= 2) ? rise_t[1] - rise_t[0] : 0;
        tot++; if (iv < MG + RC - 20 || iv > MG + RC + 50) begin bad++; $display("FAIL refresh_interval got=%0d want=%0d..%0d", iv, MG + RC - 20, MG + RC + 50); end
    endtask
`endif
    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        test_reset();
        test_fixed();
        test_random();
`ifdef AUTO_REFRESH_EN
        test_refresh();
`else
        test_back_to_back();
        test_reset_mid();
        test_held_start();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
